// File: rtl/nios2_debug_mem_master_pkg.sv
// ----------------------------------------------------------------------------
// nios2_dbg_pkg
// Shared definitions for the Nios II debug memory master:
//   - state_e         : transfer FSM states
//   - JDO_* constants : field positions inside the 38-bit jdo command payload
//   - BYTEENABLE_ALL  : full-word byte enable driven on every transfer
//   - cmd_t / decode_cmd : resolves simultaneous strobes to a single winner
// ----------------------------------------------------------------------------
package nios2_dbg_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2
   } state_e;

   localparam int JDO_ADDR_MSB   = 31;
   localparam int JDO_ADDR_LSB   = 2;
   localparam int JDO_AUTORD_BIT = 34;
   localparam int JDO_DATA_MSB   = 31;

   localparam logic [3:0] BYTEENABLE_ALL = 4'hF;

   // At most one field is set: the strobe that wins arbitration.
   typedef struct packed {
      logic do_load;
      logic do_write;
      logic do_read;
   } cmd_t;

   // Priority: load-address > write > read-next.
   function automatic cmd_t decode_cmd(input logic load_a,
                                       input logic write_b,
                                       input logic read_n);
      cmd_t c;
      c.do_load  = load_a;
      c.do_write = write_b & ~load_a;
      c.do_read  = read_n & ~load_a & ~write_b;
      return c;
   endfunction

endpackage

// File: rtl/nios2_debug_mem_master_if.sv
// ----------------------------------------------------------------------------
// nios2_debug_mem_master_if
// Single-word Avalon-MM bus between the debug memory master and its slave.
//   master modport : drives address/read/write/writedata/byteenable,
//                    samples readdata/waitrequest
//   slave modport  : the mirror image
// ----------------------------------------------------------------------------
interface nios2_debug_mem_master_if;

   logic [31:0] avm_address;
   logic        avm_read;
   logic        avm_write;
   logic [31:0] avm_writedata;
   logic [3:0]  avm_byteenable;
   logic [31:0] avm_readdata;
   logic        avm_waitrequest;

   modport master (
      output avm_address,
      output avm_read,
      output avm_write,
      output avm_writedata,
      output avm_byteenable,
      input  avm_readdata,
      input  avm_waitrequest
   );

   modport slave (
      input  avm_address,
      input  avm_read,
      input  avm_write,
      input  avm_writedata,
      input  avm_byteenable,
      output avm_readdata,
      output avm_waitrequest
   );

endinterface

// File: rtl/nios2_debug_mem_master_timeout_ctr.sv
// ----------------------------------------------------------------------------
// nios2_dbg_timeout_ctr
// Counts stalled bus cycles of the transfer in flight.
//   clk, reset : system clock, asynchronous active-high reset
//   clear      : return the count to zero (held while no transfer is active)
//   enable     : the current cycle is a stalled request cycle
//   expired    : this stalled cycle is the one that brings the count to
//                TIMEOUT_CYCLES; the transfer must be aborted on this edge
// TIMEOUT_CYCLES must be at least 2.
// ----------------------------------------------------------------------------
module nios2_dbg_timeout_ctr #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Looks one count ahead so the abort lands on the same edge the count
   // reaches TIMEOUT_CYCLES, not one cycle later.
   assign expired = enable && !clear && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      // NOTE: assign the default first so every path writes cnt_d and no latch is inferred.
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && (cnt_q != CNT_W'(TIMEOUT_CYCLES))) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/nios2_debug_mem_master.sv
// ----------------------------------------------------------------------------
// nios2_debug_mem_master
// Executes JTAG debug memory commands as single-word Avalon-MM transfers.
//   clk, reset              : system clock, asynchronous active-high reset
//   jdo[37:0]               : command payload, stable while a strobe is high
//   take_action_ocimem_a    : load address (jdo[34] also starts a read)
//   take_action_ocimem_b    : write jdo[31:0] at the current address
//   take_no_action_ocimem_a : read at the current address
//   MonDReg                 : data of the last completed read
//   monitor_ready           : no transfer in flight
//   monitor_error           : last command timed out or was dropped as busy
//   avm                     : Avalon-MM master port (word aligned, all bytes)
// Every output comes straight from a flop.
// ----------------------------------------------------------------------------
module nios2_debug_mem_master
   import nios2_dbg_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [37:0]                     jdo,
   input  logic                            take_action_ocimem_a,
   input  logic                            take_action_ocimem_b,
   input  logic                            take_no_action_ocimem_a,
   output logic [31:0]                     MonDReg,
   output logic                            monitor_ready,
   output logic                            monitor_error,
   nios2_debug_mem_master_if.master        avm
);

   // Word address; the byte address is {addr_q, 2'b00}.
   logic [29:0] addr_q,      addr_d;
   logic [31:0] wdata_q,     wdata_d;
   logic [31:0] mon_dreg_q,  mon_dreg_d;
   logic        ready_q,     ready_d;
   logic        error_q,     error_d;
   logic        read_q,      read_d;
   logic        write_q,     write_d;
   state_e      state_q,     state_d;

   cmd_t cmd;
   logic any_strobe;
   logic busy;
   logic tmo_expired;

   // Routing, reserved and opcode bits of jdo are consumed upstream.
   logic unused_jdo_bits;
   assign unused_jdo_bits = ^{jdo[37:35], jdo[33:32]};

   assign cmd        = decode_cmd(take_action_ocimem_a, take_action_ocimem_b,
                                  take_no_action_ocimem_a);
   assign any_strobe = take_action_ocimem_a | take_action_ocimem_b |
                       take_no_action_ocimem_a;
   assign busy       = (state_q == READ) || (state_q == WRITE);

   nios2_dbg_timeout_ctr #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .clear   (!busy),
      .enable  (busy && avm.avm_waitrequest),
      .expired (tmo_expired)
   );

   always_comb begin
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      mon_dreg_d = mon_dreg_q;
      ready_d    = ready_q;
      error_d    = error_q;
      read_d     = read_q;
      write_d    = write_q;
      state_d    = state_q;

      case (state_q)
         IDLE: begin
            if (cmd.do_load) begin
               addr_d  = jdo[JDO_ADDR_MSB:JDO_ADDR_LSB];
               error_d = 1'b0;
               if (jdo[JDO_AUTORD_BIT]) begin
                  state_d = READ;
                  read_d  = 1'b1;
                  ready_d = 1'b0;
               end
            end else if (cmd.do_write) begin
               wdata_d = jdo[JDO_DATA_MSB:0];
               error_d = 1'b0;
               state_d = WRITE;
               write_d = 1'b1;
               ready_d = 1'b0;
            end else if (cmd.do_read) begin
               error_d = 1'b0;
               state_d = READ;
               read_d  = 1'b1;
               ready_d = 1'b0;
            end
         end

         READ, WRITE: begin
            // A command cannot be queued behind a transfer; flag it and
            // let the transfer in flight carry on untouched.
            if (any_strobe) begin
               error_d = 1'b1;
            end
            if (!avm.avm_waitrequest) begin
               if (state_q == READ) begin
                  mon_dreg_d = avm.avm_readdata;
               end
               addr_d  = addr_q + 30'd1;   // wraps 0xFFFF_FFFC -> 0x0
               ready_d = 1'b1;
               read_d  = 1'b0;
               write_d = 1'b0;
               state_d = IDLE;
            end else if (tmo_expired) begin
               // Abort: address and read data are left as they were.
               error_d = 1'b1;
               ready_d = 1'b1;
               read_d  = 1'b0;
               write_d = 1'b0;
               state_d = IDLE;
            end
         end

         default: begin
            ready_d = 1'b1;
            read_d  = 1'b0;
            write_d = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q     <= '0;
         wdata_q    <= '0;
         mon_dreg_q <= '0;
         ready_q    <= 1'b1;
         error_q    <= 1'b0;
         read_q     <= 1'b0;
         write_q    <= 1'b0;
         state_q    <= IDLE;
      end else begin
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         mon_dreg_q <= mon_dreg_d;
         ready_q    <= ready_d;
         error_q    <= error_d;
         read_q     <= read_d;
         write_q    <= write_d;
         state_q    <= state_d;
      end
   end

   assign MonDReg            = mon_dreg_q;
   assign monitor_ready      = ready_q;
   assign monitor_error      = error_q;
   assign avm.avm_address    = {addr_q, 2'b00};
   assign avm.avm_read       = read_q;
   assign avm.avm_write      = write_q;
   assign avm.avm_writedata  = wdata_q;
   assign avm.avm_byteenable = BYTEENABLE_ALL;

endmodule

// File: tb/tb_nios2_debug_mem_master.sv
// ----------------------------------------------------------------------------
// Self-checking bench for nios2_debug_mem_master (TIMEOUT_CYCLES = 8).
// The bench acts as the debug slave and as the Avalon slave. A command-level
// model (byte address, last read data, last write data, error flag) predicts
// the outcome of every command from its strobes, jdo, wait count and data.
// ----------------------------------------------------------------------------
module tb_nios2_debug_mem_master;

   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic [37:0] jdo;
   logic        ta_a, ta_b, tna_a;
   logic [31:0] mon_dreg;
   logic        mon_ready, mon_error;

   nios2_debug_mem_master_if bus();

   nios2_debug_mem_master #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk                     (clk),
      .reset                   (reset),
      .jdo                     (jdo),
      .take_action_ocimem_a    (ta_a),
      .take_action_ocimem_b    (ta_b),
      .take_no_action_ocimem_a (tna_a),
      .MonDReg                 (mon_dreg),
      .monitor_ready           (mon_ready),
      .monitor_error           (mon_error),
      .avm                     (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state.
   logic [31:0] m_addr, m_mon, m_wdata;
   logic        m_err;
   // Model prediction for the most recent command.
   int          e_req;    // request cycles
   int          e_kind;   // 0 none, 1 read, 2 write
   logic [31:0] e_addr;   // address the transfer uses

   // Observations of the most recent command.
   int          o_req;
   logic        o_stable, o_wrote, o_read, o_busy_ok;
   logic [31:0] o_addr, o_wd;

   task automatic model_reset();
      m_addr = '0; m_mon = '0; m_wdata = '0; m_err = 1'b0;
   endtask

   task automatic model_cmd(input logic a, input logic b, input logic nr,
                            input logic [37:0] j, input int w, input logic [31:0] rd);
      e_kind = 0;
      if (a) begin
         m_addr = {j[31:2], 2'b00};
         m_err  = 1'b0;
         if (j[34]) e_kind = 1;
      end else if (b) begin
         m_wdata = j[31:0];
         m_err   = 1'b0;
         e_kind  = 2;
      end else if (nr) begin
         m_err  = 1'b0;
         e_kind = 1;
      end
      e_addr = m_addr;
      e_req  = 0;
      if (e_kind != 0) begin
         if (w >= TMO) begin
            e_req = TMO;
            m_err = 1'b1;
         end else begin
            e_req = w + 1;
            if (e_kind == 1) m_mon = rd;
            m_addr = m_addr + 32'd4;
         end
      end
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      ta_a = 1'b0; ta_b = 1'b0; tna_a = 1'b0; jdo = '0;
      bus.avm_waitrequest = 1'b0; bus.avm_readdata = '0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   // Issue one command from IDLE; the slave stalls w cycles then answers rd.
   // Returns at the first negedge with no request pending.
   task automatic do_cmd(input logic a, input logic b, input logic nr,
                         input logic [37:0] j, input int w, input logic [31:0] rd);
      model_cmd(a, b, nr, j, w, rd);
      @(negedge clk);
      jdo = j; ta_a = a; ta_b = b; tna_a = nr;
      bus.avm_readdata = rd;
      bus.avm_waitrequest = (w > 0);
      @(negedge clk);
      ta_a = 1'b0; ta_b = 1'b0; tna_a = 1'b0;
      o_req = 0; o_stable = 1'b1; o_wrote = 1'b0; o_read = 1'b0; o_busy_ok = 1'b1;
      o_addr = bus.avm_address; o_wd = bus.avm_writedata;
      for (int k = 0; k < 64; k++) begin
         if (!(bus.avm_read || bus.avm_write)) break;
         o_req++;
         if (bus.avm_write) o_wrote = 1'b1;
         if (bus.avm_read)  o_read  = 1'b1;
         if (mon_ready)     o_busy_ok = 1'b0;
         if (bus.avm_address !== o_addr || bus.avm_writedata !== o_wd) o_stable = 1'b0;
         bus.avm_waitrequest = (k < w);
         @(negedge clk);
      end
      bus.avm_waitrequest = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      ta_a = 1'b0; ta_b = 1'b0; tna_a = 1'b0; jdo = '0;
      bus.avm_waitrequest = 1'b0; bus.avm_readdata = '0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      @(negedge clk);
      n_cmp++; if (mon_dreg !== 32'h0) begin n_bad++; $display("FAIL reset_mon: got %h exp 0", mon_dreg); end
      n_cmp++; if (mon_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b exp 1", mon_ready); end
      n_cmp++; if (mon_error !== 1'b0) begin n_bad++; $display("FAIL reset_error: got %b exp 0", mon_error); end
      n_cmp++; if ({bus.avm_read, bus.avm_write} !== 2'b00) begin n_bad++; $display("FAIL reset_req: got %b exp 00", {bus.avm_read, bus.avm_write}); end
      n_cmp++; if (bus.avm_address !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h exp 0", bus.avm_address); end
      n_cmp++; if (bus.avm_writedata !== 32'h0) begin n_bad++; $display("FAIL reset_wdata: got %h exp 0", bus.avm_writedata); end
      n_cmp++; if (bus.avm_byteenable !== 4'hF) begin n_bad++; $display("FAIL reset_be: got %h exp f", bus.avm_byteenable); end
   endtask

   task automatic test_load_addr();
      do_cmd(1'b1, 1'b0, 1'b0, {3'b0, 1'b1, 2'b0, 32'h0000_1000}, 0, 32'hCAFE_F00D);
      n_cmp++; if (o_addr !== 32'h1000) begin n_bad++; $display("FAIL load_addr: got %h exp 1000", o_addr); end
      n_cmp++; if (o_req !== 1 || o_read !== 1'b1) begin n_bad++; $display("FAIL load_rdreq: got %0d/%b exp 1/1", o_req, o_read); end
      n_cmp++; if (mon_dreg !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL load_mon: got %h exp cafef00d", mon_dreg); end
      n_cmp++; if (mon_ready !== 1'b1) begin n_bad++; $display("FAIL load_ready: got %b exp 1", mon_ready); end
      do_cmd(1'b0, 1'b0, 1'b1, '0, 0, 32'h0BAD_BEEF);
      n_cmp++; if (o_addr !== 32'h1004) begin n_bad++; $display("FAIL load_next_addr: got %h exp 1004", o_addr); end
   endtask

   task automatic test_write_waits();
      do_cmd(1'b0, 1'b1, 1'b0, {6'b0, 32'h1234_5678}, 3, 32'hFFFF_FFFF);
      n_cmp++; if (o_req !== 4 || o_wrote !== 1'b1 || o_read !== 1'b0) begin n_bad++; $display("FAIL wr_req: got %0d/%b/%b exp 4/1/0", o_req, o_wrote, o_read); end
      n_cmp++; if (o_stable !== 1'b1) begin n_bad++; $display("FAIL wr_stable: got %b exp 1", o_stable); end
      n_cmp++; if (o_addr !== 32'h1008) begin n_bad++; $display("FAIL wr_addr: got %h exp 1008", o_addr); end
      n_cmp++; if (o_wd !== 32'h1234_5678) begin n_bad++; $display("FAIL wr_data: got %h exp 12345678", o_wd); end
      n_cmp++; if (o_busy_ok !== 1'b1) begin n_bad++; $display("FAIL wr_busy_ready: got %b exp 1", o_busy_ok); end
      n_cmp++; if (mon_dreg !== 32'h0BAD_BEEF) begin n_bad++; $display("FAIL wr_mon: got %h exp 0badbeef", mon_dreg); end
      do_cmd(1'b0, 1'b0, 1'b1, '0, 0, 32'h5555_AAAA);
      n_cmp++; if (o_addr !== 32'h100C) begin n_bad++; $display("FAIL wr_next_addr: got %h exp 100c", o_addr); end
   endtask

   task automatic test_timeout();
      do_cmd(1'b0, 1'b0, 1'b1, '0, 1000, 32'hDEAD_0000);
      n_cmp++; if (o_req !== TMO) begin n_bad++; $display("FAIL tmo_cycles: got %0d exp %0d", o_req, TMO); end
      n_cmp++; if (mon_error !== 1'b1 || mon_ready !== 1'b1) begin n_bad++; $display("FAIL tmo_flags: got %b%b exp 11", mon_error, mon_ready); end
      n_cmp++; if (mon_dreg !== 32'h5555_AAAA) begin n_bad++; $display("FAIL tmo_mon: got %h exp 5555aaaa", mon_dreg); end
      do_cmd(1'b0, 1'b0, 1'b1, '0, 1, 32'h600D_0001);
      n_cmp++; if (o_addr !== 32'h1010) begin n_bad++; $display("FAIL tmo_addr_kept: got %h exp 1010", o_addr); end
      n_cmp++; if (mon_error !== 1'b0) begin n_bad++; $display("FAIL tmo_err_clear: got %b exp 0", mon_error); end
      n_cmp++; if (mon_dreg !== 32'h600D_0001) begin n_bad++; $display("FAIL tmo_good_mon: got %h exp 600d0001", mon_dreg); end
   endtask

   task automatic test_busy_drop();
      @(negedge clk);
      tna_a = 1'b1; bus.avm_waitrequest = 1'b1; bus.avm_readdata = 32'hA5A5_0001;
      @(negedge clk);
      tna_a = 1'b0;
      @(negedge clk);
      tna_a = 1'b1;                       // arrives while the read is stalled
      @(negedge clk);
      tna_a = 1'b0;
      n_cmp++; if (mon_error !== 1'b1 || bus.avm_read !== 1'b1) begin n_bad++; $display("FAIL drop_flag: got err %b rd %b exp 1 1", mon_error, bus.avm_read); end
      n_cmp++; if (bus.avm_address !== 32'h1014) begin n_bad++; $display("FAIL drop_addr_held: got %h exp 1014", bus.avm_address); end
      @(negedge clk);
      bus.avm_waitrequest = 1'b0;
      @(negedge clk);
      n_cmp++; if (mon_ready !== 1'b1 || bus.avm_read !== 1'b0) begin n_bad++; $display("FAIL drop_done: got rdy %b rd %b exp 1 0", mon_ready, bus.avm_read); end
      n_cmp++; if (mon_dreg !== 32'hA5A5_0001) begin n_bad++; $display("FAIL drop_mon: got %h exp a5a50001", mon_dreg); end
      n_cmp++; if (mon_error !== 1'b1) begin n_bad++; $display("FAIL drop_err_kept: got %b exp 1", mon_error); end
      m_mon = 32'hA5A5_0001; m_addr = m_addr + 32'd4; m_err = 1'b1;
      do_cmd(1'b0, 1'b0, 1'b1, '0, 0, 32'h0000_0042);
      n_cmp++; if (o_addr !== 32'h1018) begin n_bad++; $display("FAIL drop_next_addr: got %h exp 1018", o_addr); end
   endtask

   task automatic test_priority();
      do_cmd(1'b1, 1'b1, 1'b0, {6'b0, 32'h0000_2000}, 0, 32'h0);
      n_cmp++; if (o_req !== 0) begin n_bad++; $display("FAIL prio_ab_req: got %0d exp 0", o_req); end
      n_cmp++; if (bus.avm_writedata !== 32'h1234_5678) begin n_bad++; $display("FAIL prio_ab_wdata: got %h exp 12345678", bus.avm_writedata); end
      do_cmd(1'b0, 1'b0, 1'b1, '0, 0, 32'h0000_0077);
      n_cmp++; if (o_addr !== 32'h2000) begin n_bad++; $display("FAIL prio_ab_addr: got %h exp 2000", o_addr); end
      do_cmd(1'b0, 1'b1, 1'b1, {6'b0, 32'h7777_0000}, 0, 32'h0);
      n_cmp++; if (o_wrote !== 1'b1 || o_read !== 1'b0) begin n_bad++; $display("FAIL prio_bn: got wr %b rd %b exp 1 0", o_wrote, o_read); end
   endtask

   task automatic test_wrap();
      do_cmd(1'b1, 1'b0, 1'b0, {3'b0, 1'b1, 2'b0, 32'hFFFF_FFFC}, 0, 32'h1111_2222);
      n_cmp++; if (o_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_top: got %h exp fffffffc", o_addr); end
      do_cmd(1'b0, 1'b0, 1'b1, '0, 0, 32'h3333_4444);
      n_cmp++; if (o_addr !== 32'h0) begin n_bad++; $display("FAIL wrap_zero: got %h exp 0", o_addr); end
   endtask

   task automatic test_random();
      logic [2:0]  r;
      logic [63:0] t;
      int          w;
      logic [31:0] rd;
      apply_reset();
      for (int i = 0; i < 40; i++) begin
         r = 3'($urandom_range(1, 7));
         t = {$urandom, $urandom};
         w = $urandom_range(0, TMO + 2);
         rd = $urandom;
         do_cmd(r[0], r[1], r[2], t[37:0], w, rd);
         n_cmp++; if (o_req !== e_req) begin n_bad++; $display("FAIL rnd%0d_req: got %0d exp %0d", i, o_req, e_req); end
         n_cmp++; if (o_wrote !== (e_kind == 2)) begin n_bad++; $display("FAIL rnd%0d_kind: got wr %b exp kind %0d", i, o_wrote, e_kind); end
         n_cmp++; if (mon_dreg !== m_mon) begin n_bad++; $display("FAIL rnd%0d_mon: got %h exp %h", i, mon_dreg, m_mon); end
         n_cmp++; if (mon_error !== m_err || mon_ready !== 1'b1) begin n_bad++; $display("FAIL rnd%0d_flags: got err %b rdy %b exp %b 1", i, mon_error, mon_ready, m_err); end
         if (e_kind != 0) begin
            n_cmp++; if (o_addr !== e_addr) begin n_bad++; $display("FAIL rnd%0d_addr: got %h exp %h", i, o_addr, e_addr); end
            n_cmp++; if (o_stable !== 1'b1 || o_busy_ok !== 1'b1) begin n_bad++; $display("FAIL rnd%0d_hold: got stable %b busy %b exp 1 1", i, o_stable, o_busy_ok); end
         end
         if (e_kind == 2) begin
            n_cmp++; if (o_wd !== m_wdata) begin n_bad++; $display("FAIL rnd%0d_wdata: got %h exp %h", i, o_wd, m_wdata); end
         end
      end
   endtask

   task automatic test_reset_mid_write();
      @(negedge clk);
      ta_b = 1'b1; jdo = {6'b0, 32'h9ABC_DEF0}; bus.avm_waitrequest = 1'b1;
      @(negedge clk);
      ta_b = 1'b0;
      n_cmp++; if (bus.avm_write !== 1'b1) begin n_bad++; $display("FAIL rst_wr_started: got %b exp 1", bus.avm_write); end
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      n_cmp++; if (bus.avm_write !== 1'b0 || bus.avm_read !== 1'b0) begin n_bad++; $display("FAIL rst_wr_drop: got wr %b rd %b exp 0 0", bus.avm_write, bus.avm_read); end
      n_cmp++; if (bus.avm_address !== 32'h0 || bus.avm_writedata !== 32'h0) begin n_bad++; $display("FAIL rst_wr_bus: got %h %h exp 0 0", bus.avm_address, bus.avm_writedata); end
      n_cmp++; if (mon_dreg !== 32'h0 || mon_ready !== 1'b1 || mon_error !== 1'b0) begin n_bad++; $display("FAIL rst_wr_mon: got %h %b %b exp 0 1 0", mon_dreg, mon_ready, mon_error); end
      @(negedge clk);
      reset = 1'b0;
      bus.avm_waitrequest = 1'b0;
      model_reset();
      do_cmd(1'b0, 1'b0, 1'b1, '0, 0, 32'h0000_ABCD);
      n_cmp++; if (o_addr !== 32'h0 || mon_dreg !== 32'h0000_ABCD) begin n_bad++; $display("FAIL rst_wr_after: got %h %h exp 0 0000abcd", o_addr, mon_dreg); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_load_addr();
      test_write_waits();
      test_timeout();
      test_busy_drop();
      test_priority();
      test_wrap();
      test_random();
      test_reset_mid_write();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/nios2_debug_mem_master.md
# nios2_debug_mem_master

Executes JTAG debug memory commands on behalf of the host. It sits directly downstream of the Nios II debug-slave system-clock stage: it consumes `jdo` and the `take_action_ocimem_*` strobes, and performs single-word Avalon-MM reads and writes. It returns `MonDReg`, `monitor_ready` and `monitor_error` to the debug slave for the next JTAG capture.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1024, waitrequest cycles tolerated before a transfer is aborted (≥2).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- jdo  input  38  command payload from the debug slave, stable while any strobe is high
- take_action_ocimem_a  input  1  load-address strobe, one cycle
- take_action_ocimem_b  input  1  write strobe, one cycle
- take_no_action_ocimem_a  input  1  read-next strobe, one cycle
- MonDReg  output  32  last read data
- monitor_ready  output  1  no transfer in flight
- monitor_error  output  1  last command timed out or was dropped
- avm_address  output  32  byte address, bits [1:0] always 0
- avm_read  output  1  Avalon read request
- avm_write  output  1  Avalon write request
- avm_writedata  output  32  write data
- avm_byteenable  output  4  constant 4'hF
- avm_readdata  input  32  read data, valid in the cycle avm_waitrequest is low with avm_read high
- avm_waitrequest  input  1  slave stall

## Operation
- Internal state: addr_q[31:2], wdata_q[31:0], FSM {IDLE, READ, WRITE}, timeout counter.
- Strobe priority when several are high together: ocimem_a > ocimem_b > no_action_ocimem_a. Only the winner is executed.
- ocimem_a: addr_q <= jdo[31:2]. If jdo[34]=1, a READ at the new address is also started; otherwise the FSM stays IDLE and monitor_ready stays 1.
- ocimem_b: wdata_q <= jdo[31:0], enter WRITE at addr_q.
- no_action_ocimem_a: enter READ at addr_q.
- Accepting any command clears monitor_error. Starting a transfer clears monitor_ready.
- READ: avm_read=1 until avm_waitrequest=0. On that edge: MonDReg <= avm_readdata, addr_q <= addr_q+1 (mod 2^30), monitor_ready <= 1, go to IDLE.
- WRITE: avm_write=1 until avm_waitrequest=0. On that edge: addr_q increments, monitor_ready <= 1, go to IDLE. MonDReg is unchanged.
- Timeout: the counter counts stalled cycles in READ/WRITE. When it reaches TIMEOUT_CYCLES: drop avm_read/avm_write, set monitor_error=1, monitor_ready=1, go to IDLE. addr_q and MonDReg are unchanged.
- Any strobe arriving outside IDLE is dropped, sets monitor_error=1, and leaves the transfer in flight untouched.
- Address wrap: 32'hFFFF_FFFC increments to 32'h0000_0000.

## Timing
- Reset values: MonDReg=0, monitor_ready=1, monitor_error=0, avm_read=0, avm_write=0, avm_address=0, avm_writedata=0, addr_q=0, FSM=IDLE, counter=0.
- Reset mid-transfer: the request deasserts immediately (asynchronous) and all state returns to reset values.
- Strobe at edge n: the request is asserted from cycle n+1. With zero wait states, monitor_ready=1 and MonDReg are valid at cycle n+2.
- Latency is 2 + W cycles for W waitrequest cycles.
- avm_address, avm_writedata and the request are held constant while avm_waitrequest=1.
- Timeout abort: the request drops on the edge where the counter reaches TIMEOUT_CYCLES.
- All outputs are registered. There is no combinational path from input to output.

## Structure
- Package nios2_dbg_pkg holds:
  - state enum {IDLE, READ, WRITE};
  - JDO field constants: JDO_ADDR_MSB=31, JDO_ADDR_LSB=2, JDO_AUTORD_BIT=34, JDO_DATA_MSB=31;
  - BYTEENABLE_ALL=4'hF.
- One sub-module, nios2_dbg_timeout_ctr:
  - parameterised by TIMEOUT_CYCLES;
  - inputs: clear, enable;
  - output: expired.

## Test plan
- Load address: ocimem_a with jdo[31:0]=32'h0000_1000, jdo[34]=1, slave returns 32'hCAFE_F00D with 0 waits. Expect avm_address=32'h1000 at n+1, MonDReg=32'hCAFE_F00D and monitor_ready=1 at n+2, next address 32'h1004.
- Write with waits: ocimem_b with jdo[31:0]=32'h1234_5678, waitrequest high for 3 cycles. Expect avm_write held 4 cycles with stable address and data, then the address increments by 4 and MonDReg is unchanged.
- Timeout: TIMEOUT_CYCLES=8, waitrequest stuck high. Expect the request to drop after 8 stalled cycles with monitor_error=1, monitor_ready=1, and addr_q unchanged. A following good read clears monitor_error.
- Busy drop and priority:
  - A no_action_ocimem_a during a stalled READ: expect monitor_error=1 and the in-flight read to complete normally.
  - ocimem_a and ocimem_b strobed in the same cycle: expect an address load only, with no write.
- Wrap and reset:
  - Read at 32'hFFFF_FFFC: expect the next address to be 32'h0.
  - Reset asserted mid-WRITE: expect avm_write=0 immediately and all outputs at reset values.
